// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Leading-zero blanking in the top is selected with SEG7_LZB_EN.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int unsigned CNT_W     = 4;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [3:0]  AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_mux_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode scan driver stepped by a synchronized scan_clk.
// Optional leading-zero blanking: define SEG7_LZB_EN.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_idx
);

  localparam logic [1:0]       LAST_IDX = 2'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

  logic             sync1, sync2, hist, step;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_d;
  logic             snap;
  logic [15:0]      shadow_val;
  logic [3:0]       shadow_dp;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             lz_blank;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_n_d;

  // scan_clk is data: two-flop synchronizer, history flop, registered edge pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      step  <= 1'b0;
    end else begin
      sync1 <= scan_clk;
      sync2 <= sync1;
      hist  <= sync2;
      step  <= sync2 & ~hist;
    end
  end

  // State, counter, digit index, snapshot and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      digit_idx  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_idx <= idx_d;
      if (snap) begin
        shadow_val <= value;
        shadow_dp  <= dp;
      end
      an   <= an_d;
      seg  <= seg_d;
      dp_n <= dp_n_d;
    end
  end

  // Next-state logic; disable wins over step, steps outside SHOW are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = digit_idx;
    snap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
          snap    = 1'b1;
        end
        BLANK: begin
          if (cnt_q == '0) state_d = SHOW;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        SHOW: begin
          if (step) begin
            state_d = BLANK;
            cnt_d   = CNT_LOAD;
            if (digit_idx == LAST_IDX) begin
              idx_d = '0;
              snap  = 1'b1;
            end else begin
              idx_d = digit_idx + 2'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Shadow is always loaded at least one cycle before the SHOW it feeds.
  assign nibble = shadow_val[4*int'(idx_d) +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_c  (dec_seg)
  );

`ifdef SEG7_LZB_EN
  assign lz_blank = (idx_d != 2'd0) && ((shadow_val >> (4*int'(idx_d))) == 16'h0000);
`else
  assign lz_blank = 1'b0;
`endif

  // Output values follow the next state so they line up with it.
  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (state_d == SHOW) begin
      an_d   = ~(4'(1) << idx_d);
      seg_d  = lz_blank ? SEG_BLANK : dec_seg;
      dp_n_d = ~shadow_dp[idx_d];
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux (vector table plus scan sequences).
module tb_seg7_scan_mux;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        scan_clk;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_idx;

  int checks   = 0;
  int failures = 0;

  seg7_scan_mux #(.NUM_DIGITS(4), .BLANK_CYCLES(2)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .scan_clk  (scan_clk),
    .enable    (enable),
    .value     (value),
    .dp        (dp),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .digit_idx (digit_idx)
  );

  always #5 clk_in = ~clk_in;

`ifdef SEG7_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // Raise scan_clk and check the 3-edge latency, 2-cycle gap, then the new digit.
  task automatic scan_step(input string name, input logic [3:0] exp_an,
                           input logic [6:0] exp_seg, input logic exp_dpn);
    logic [3:0] prev;
    prev = an;
    scan_clk = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk({name, "_hold"}, 32'(an), 32'(prev));
    end
    scan_clk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({name, "_gap"}, 32'(an), 32'hF);
    end
    tick();
    chk({name, "_an"}, 32'(an), 32'(exp_an));
    chk({name, "_seg"}, 32'(seg), 32'(exp_seg));
    chk({name, "_dpn"}, 32'(dp_n), 32'(exp_dpn));
  endtask

  initial begin
    tv[0] = '{16'h0050, 4'b0000, {LZ, LZ, 7'h12, 7'h40}, 4'b1111};
    tv[1] = '{16'h89AB, 4'b1111, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b0000};
    tv[2] = '{16'hCDEF, 4'b1000, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b0111};
    tv[3] = '{16'h5670, 4'b0001, {7'h12, 7'h02, 7'h78, 7'h40}, 4'b1110};
    tv[4] = '{16'h0000, 4'b0000, {LZ, LZ, LZ, 7'h40}, 4'b1111};
    tv[5] = '{16'h1000, 4'b0010, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b1101};

    rst = 1'b1; scan_clk = 1'b0; enable = 1'b0; value = '0; dp = '0;
    repeat (3) tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dpn", 32'(dp_n), 32'h1);
    chk("rst_idx", 32'(digit_idx), 32'h0);

    // Enable with 1234: two blank cycles after the entry edge, then digit 0.
    rst = 1'b0; enable = 1'b1; value = 16'h1234; dp = 4'b0000;
    tick(); chk("en_blank1", 32'(an), 32'hF);
    tick(); chk("en_blank2", 32'(seg), 32'h7F);
    tick();
    chk("en_d0_an", 32'(an), 32'hE);
    chk("en_d0_seg", 32'(seg), 32'h19);
    chk("en_d0_idx", 32'(digit_idx), 32'h0);
    scan_step("s_d1", 4'hD, 7'h30, 1'b1);
    scan_step("s_d2", 4'hB, 7'h24, 1'b1);
    scan_step("s_d3", 4'h7, 7'h79, 1'b1);
    scan_step("s_wrap", 4'hE, 7'h19, 1'b1);
    chk("wrap_idx", 32'(digit_idx), 32'h0);

    // Mid-frame value change must not tear the current frame.
    scan_step("snap_d1", 4'hD, 7'h30, 1'b1);
    value = 16'hFFFF;
    scan_step("snap_d2", 4'hB, 7'h24, 1'b1);
    scan_step("snap_d3", 4'h7, 7'h79, 1'b1);
    scan_step("snap_n0", 4'hE, 7'h0E, 1'b1);
    scan_step("snap_n1", 4'hD, 7'h0E, 1'b1);
    scan_step("snap_n2", 4'hB, 7'h0E, 1'b1);
    scan_step("snap_n3", 4'h7, 7'h0E, 1'b1);

    // Decimal point on digit 2 only, loaded at the next frame start.
    dp = 4'b0100;
    scan_step("dp_d0", 4'hE, 7'h0E, 1'b1);
    scan_step("dp_d1", 4'hD, 7'h0E, 1'b1);
    scan_step("dp_d2", 4'hB, 7'h0E, 1'b0);
    chk("dp_idx2", 32'(digit_idx), 32'h2);

    // Disable on the same edge a step would act: disable wins.
    scan_clk = 1'b1;
    repeat (3) tick();
    chk("drop_pre_an", 32'(an), 32'hB);
    enable = 1'b0;
    tick();
    chk("drop_an", 32'(an), 32'hF);
    chk("drop_idx", 32'(digit_idx), 32'h0);
    chk("drop_dpn", 32'(dp_n), 32'h1);
    scan_clk = 1'b0;
    repeat (4) tick();
    chk("idle_an", 32'(an), 32'hF);
    enable = 1'b1;
    repeat (2) tick();
    chk("reen_blank", 32'(an), 32'hF);
    tick();
    chk("reen_an", 32'(an), 32'hE);
    chk("reen_seg", 32'(seg), 32'h0E);
    chk("reen_idx", 32'(digit_idx), 32'h0);

    // Table: fresh enable per vector, then walk all four digits.
    for (int v = 0; v < 6; v++) begin
      enable = 1'b0;
      tick();
      value = tv[v].value; dp = tv[v].dp; enable = 1'b1;
      repeat (3) tick();
      chk($sformatf("tv%0d_d0_an", v), 32'(an), 32'hE);
      chk($sformatf("tv%0d_d0_seg", v), 32'(seg), 32'(tv[v].seg[0]));
      chk($sformatf("tv%0d_d0_dpn", v), 32'(dp_n), 32'(tv[v].dpn[0]));
      for (int d = 1; d < 4; d++)
        scan_step($sformatf("tv%0d_d%0d", v, d), an_of(d), tv[v].seg[d], tv[v].dpn[d]);
    end

    // Synchronous reset mid-SHOW overrides enable.
    rst = 1'b1;
    tick();
    chk("rst_mid_an", 32'(an), 32'hF);
    chk("rst_mid_seg", 32'(seg), 32'h7F);
    chk("rst_mid_idx", 32'(digit_idx), 32'h0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed driver for a common-anode 4-digit seven-segment display, sitting directly downstream of the clock divider. It consumes the divider's slow square-wave output as a scan-rate reference, edge-detects it in the system clock domain, and steps through the digits. Each step shows one hex nibble of a frame-stable snapshot of `value`, with a short all-off blanking gap between digits to suppress ghosting.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits scanned; fixed at 4 in this revision, present for package consistency.
- `BLANK_CYCLES`, 2: `clk_in` cycles that all anodes stay off between digits; legal range 1–15.

Ports:
- `clk_in`  in  1: system clock; the block's only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `scan_clk`  in  1: divided clock from the clock divider; treated as data and synchronized, never used as a clock.
- `enable`  in  1: display on when high.
- `value`  in  16: four hex digits; digit 0 = `value[3:0]`, digit 3 = `value[15:12]`.
- `dp`  in  4: decimal point per digit, active-high.
- `an`  out  4: anode selects, active-low; bit i drives digit i.
- `seg`  out  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`  out  1: decimal point, active-low.
- `digit_idx`  out  2: index of the digit currently selected.

## Operation
- `scan_clk` passes through a 2-flop synchronizer, then a history flop. A rising edge on the synchronized signal produces a 1-cycle `step` pulse.
- States:
  - IDLE: all anodes off.
  - BLANK: all anodes off; down-counter runs.
  - SHOW: one anode on.
- Transitions:
  - IDLE → BLANK when `enable`=1.
  - BLANK → SHOW when the counter reaches 0, after exactly `BLANK_CYCLES` cycles.
  - SHOW → BLANK on `step`; `digit_idx` increments mod 4 on the same edge (3 wraps to 0).
  - Any state → IDLE when `enable`=0. This has priority over `step`.
- Entering IDLE clears `digit_idx` to 0.
- Snapshot: `value` and `dp` are copied into shadow registers on every entry to BLANK whose target digit is 0, including the first BLANK after IDLE. Digits 1–3 of a frame always come from that snapshot, so mid-frame input changes never tear.
- In SHOW:
  - `an` = ~(1<<`digit_idx`).
  - `seg` = hex decode of the shadow nibble.
  - `dp_n` = ~shadow_dp[`digit_idx`].
- In IDLE/BLANK: `an`=4'hF, `seg`=7'h7F, `dp_n`=1.
- All outputs are registered.
- Hex decode, active-low `{g..a}`:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- A `step` that arrives in BLANK or IDLE is dropped, not queued.

## Timing
- Reset state: IDLE, `digit_idx`=0, `an`=4'hF, `seg`=7'h7F, `dp_n`=1, shadows 0, synchronizer/history flops 0. An edge present at reset release therefore counts only if `scan_clk` is sampled high after the flops start from 0.
- `scan_clk` rising at the input to `step` high: 3 `clk_in` edges (2 sync + 1 edge detect).
- `step` to `an`=4'hF: next edge.
- New anode asserted `BLANK_CYCLES` edges after that.
- `enable` deassert to `an`=4'hF: 1 edge.
- `enable` assert to first SHOW of digit 0: 1 + `BLANK_CYCLES` edges.
- `rst` mid-SHOW: outputs take reset values on the next edge, regardless of `enable` or `step`.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Digit i>0 shows `seg`=7'h7F when shadow nibbles i..3 are all zero.
  - The anode and `dp_n` still follow normal rules.
  - Digit 0 is never blanked.
- `SEG7_LZB_EN` undefined: every digit shows its decoded nibble.

## Structure
- Package `seg7_pkg` holds:
  - state enum (IDLE, BLANK, SHOW)
  - `SEG_BLANK`=7'h7F, `AN_OFF`=4'hF
  - 16-entry hex-to-segment constant table
- Sub-module `hex_to_seg7`: combinational 4-bit → 7-bit decoder using the package table, instantiated once on the muxed shadow nibble.

## Test plan
- Reset/enable: `rst` high 3 cycles, then `enable`=1, `value`=16'h1234, `dp`=0 → `an`=F, `seg`=7F for 1+2 cycles, then `an`=E, `seg`=19 (digit 0 = 4); successive `scan_clk` edges give an D/30, B/24, 7/79, then E/19 again.
- Blanking gap: every `scan_clk` rising edge → exactly 2 cycles of `an`=F, starting 4 edges after the input edge.
- Snapshot: change `value` to 16'hFFFF while digit 1 is shown → digits 2 and 3 still show 2 and 1; the next frame shows 0E on all digits.
- Decimal point: `dp`=4'b0100 → `dp_n`=0 only while `an`=B.
- `enable` drop mid-SHOW on digit 2, with a simultaneous `step` → `an`=F next cycle, `digit_idx`=0; re-enable restarts at digit 0.
- `SEG7_LZB_EN`: `value`=16'h0050 → digits 3 and 2 show `seg`=7F; digit 1 shows 12; digit 0 shows 40. Without the macro, digits 3 and 2 show 40.
